// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the FFT frame arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fft_pkg;

  localparam int DATA_W   = 16;
  localparam int N_POINTS = 16;
  localparam int CNT_W    = $clog2(N_POINTS);

  typedef enum logic {
    IDLE = 1'b0,
    FEED = 1'b1
  } state_t;

endpackage

// File: rtl/fft_tag_fifo.sv
// 1-bit tag FIFO recording which requester owns each frame in flight.
// Latency: a pushed tag is visible at the head one edge later; pop is synchronous.
// Backpressure: registered full/empty flags; a push while full is accepted only with a pop.
module fft_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the head slot, so a push into a full FIFO is still safe.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Occupancy after this edge; feeds the registered flags.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Pointers, storage and flags; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == DEPTH_C);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/fft_frame_arbiter.sv
// Frame-level arbiter sharing one FFT core between two requesters; routes results back by tag.
// Latency: 0-cycle combinational forwarding of data/handshakes; grant takes effect one edge after request.
// Backpressure: owner sees fft_in_stall, non-owner stalled; fft_out_stall follows the tagged rsp port.
module fft_frame_arbiter #(
  parameter int N_POINTS  = fft_pkg::N_POINTS,
  parameter int DATA_W    = fft_pkg::DATA_W,
  parameter int TAG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_push,
  input  logic [DATA_W-1:0] req0_real,
  input  logic [DATA_W-1:0] req0_imag,
  output logic              req0_stall,
  input  logic              req1_push,
  input  logic [DATA_W-1:0] req1_real,
  input  logic [DATA_W-1:0] req1_imag,
  output logic              req1_stall,
  output logic              fft_in_push,
  output logic [DATA_W-1:0] fft_in_real,
  output logic [DATA_W-1:0] fft_in_imag,
  input  logic              fft_in_stall,
  input  logic              fft_out_push,
  input  logic [DATA_W-1:0] fft_out_real,
  input  logic [DATA_W-1:0] fft_out_imag,
  output logic              fft_out_stall,
  output logic              rsp0_push,
  output logic [DATA_W-1:0] rsp0_real,
  output logic [DATA_W-1:0] rsp0_imag,
  input  logic              rsp0_stall,
  output logic              rsp1_push,
  output logic [DATA_W-1:0] rsp1_real,
  output logic [DATA_W-1:0] rsp1_imag,
  input  logic              rsp1_stall,
  output logic              owner,
  output logic              busy,
  output logic              err
);

  import fft_pkg::*;

  // Counter width follows the module parameter so an override stays consistent.
  localparam int CW = $clog2(N_POINTS);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_POINTS - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] in_cnt;
  logic [CW-1:0] out_cnt;
  logic          last_served;
  logic          grant;
  logic          tag_push;
  logic          tag_pop;
  logic          tag_head;
  logic          tag_full;
  logic          tag_empty;
  logic          in_xfer;
  logic          in_last;
  logic          out_xfer;

  assign busy        = (state == FEED);
  assign fft_in_real = owner ? req1_real : req0_real;
  assign fft_in_imag = owner ? req1_imag : req0_imag;
  assign rsp0_real   = fft_out_real;
  assign rsp0_imag   = fft_out_imag;
  assign rsp1_real   = fft_out_real;
  assign rsp1_imag   = fft_out_imag;

  // Input FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbitration, next state and input-side handshakes.
  always_comb begin
    state_next  = state;
    grant       = owner;
    tag_push    = 1'b0;
    req0_stall  = 1'b1;
    req1_stall  = 1'b1;
    fft_in_push = 1'b0;
    in_xfer     = 1'b0;
    in_last     = 1'b0;
    case (state)
      IDLE: begin
        if ((req0_push || req1_push) && !tag_full) begin
          state_next = FEED;
          tag_push   = 1'b1;
          // On a tie the requester not served last wins; otherwise the sole pusher.
          grant      = (req0_push && req1_push) ? ~last_served : req1_push;
        end
      end
      FEED: begin
        fft_in_push = owner ? req1_push : req0_push;
        if (owner) begin
          req1_stall = fft_in_stall;
        end else begin
          req0_stall = fft_in_stall;
        end
        in_xfer = fft_in_push && !fft_in_stall;
        if (in_xfer && (in_cnt == LAST_IDX)) begin
          state_next = IDLE;
          in_last    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant owner, fairness memory and input sample counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner       <= 1'b0;
      last_served <= 1'b1;
      in_cnt      <= '0;
    end else begin
      if (tag_push) begin
        owner  <= grant;
        in_cnt <= '0;
      end else if (in_xfer) begin
        in_cnt <= in_cnt + 1'b1;
      end
      if (in_last) begin
        last_served <= owner;
      end
    end
  end

  // Output routing: head tag picks the rsp port; nothing flows while no frame is tagged.
  always_comb begin
    rsp0_push     = 1'b0;
    rsp1_push     = 1'b0;
    fft_out_stall = 1'b1;
    out_xfer      = 1'b0;
    if (!tag_empty) begin
      if (tag_head) begin
        rsp1_push     = fft_out_push;
        fft_out_stall = rsp1_stall;
      end else begin
        rsp0_push     = fft_out_push;
        fft_out_stall = rsp0_stall;
      end
      out_xfer = fft_out_push && !fft_out_stall;
    end
  end

  assign tag_pop = out_xfer && (out_cnt == LAST_IDX);

  // Output sample counter and sticky error for output with no tagged frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (out_xfer) begin
        out_cnt <= out_cnt + 1'b1;
      end
      if (tag_empty && fft_out_push) begin
        err <= 1'b1;
      end
    end
  end

  fft_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tag_push),
    .pop   (tag_pop),
    .din   (grant),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Bench for fft_frame_arbiter: bench plays both requesters, the FFT core (identity) and both result sinks.
// Latency: expects 0-cycle forwarding and grant-on-next-edge.
// Backpressure: knobs for fft_in_stall toggling and rsp stalls.
`timescale 1ns/1ps
module tb_fft_frame_arbiter;

  localparam int N = fft_pkg::N_POINTS;
  localparam int W = fft_pkg::DATA_W;

  typedef struct packed {
    logic         src;
    logic [W-1:0] re;
    logic [W-1:0] im;
  } smp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0_push, req1_push, req0_stall, req1_stall;
  logic [W-1:0] req0_real, req0_imag, req1_real, req1_imag;
  logic         fft_in_push, fft_in_stall;
  logic [W-1:0] fft_in_real, fft_in_imag;
  logic         fft_out_push, fft_out_stall;
  logic [W-1:0] fft_out_real, fft_out_imag;
  logic         rsp0_push, rsp1_push, rsp0_stall, rsp1_stall;
  logic [W-1:0] rsp0_real, rsp0_imag, rsp1_real, rsp1_imag;
  logic         owner, busy, err;

  int   vectors = 0;
  int   miscompares = 0;
  int   acc0 = 0, acc1 = 0, target0 = 0, target1 = 0;
  int   rsp_cnt0 = 0, rsp_cnt1 = 0;
  int   flush_cnt = 0, flush_seen = 0;
  logic spike = 1'b0, in_tog = 1'b0, out_en = 1'b0, force_out = 1'b0;
  logic rs0 = 1'b0, rs1 = 1'b0, phase = 1'b0;
  smp_t inbuf[$];
  smp_t out_q[$];
  smp_t exp_rsp[$];
  logic grant_log[$];

  // {req0_stall, req1_stall, fft_in_push, fft_out_stall, rsp0_push, rsp1_push, busy, owner, err}
  localparam logic [8:0] RESET_OUTS = 9'b1_1_0_1_0_0_0_0_0;

  fft_frame_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_push(req0_push), .req0_real(req0_real), .req0_imag(req0_imag), .req0_stall(req0_stall),
    .req1_push(req1_push), .req1_real(req1_real), .req1_imag(req1_imag), .req1_stall(req1_stall),
    .fft_in_push(fft_in_push), .fft_in_real(fft_in_real), .fft_in_imag(fft_in_imag),
    .fft_in_stall(fft_in_stall),
    .fft_out_push(fft_out_push), .fft_out_real(fft_out_real), .fft_out_imag(fft_out_imag),
    .fft_out_stall(fft_out_stall),
    .rsp0_push(rsp0_push), .rsp0_real(rsp0_real), .rsp0_imag(rsp0_imag), .rsp0_stall(rsp0_stall),
    .rsp1_push(rsp1_push), .rsp1_real(rsp1_real), .rsp1_imag(rsp1_imag), .rsp1_stall(rsp1_stall),
    .owner(owner), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Driver: all DUT inputs except reset change 1ns after the rising edge.
  initial begin
    req0_push = 1'b0; req1_push = 1'b0;
    req0_real = '0; req0_imag = '0; req1_real = '0; req1_imag = '0;
    fft_in_stall = 1'b0; fft_out_push = 1'b0; fft_out_real = '0; fft_out_imag = '0;
    rsp0_stall = 1'b0; rsp1_stall = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      phase      = ~phase;
      req0_push  = (acc0 < target0);
      req0_real  = spike ? ((acc0[3:0] == 4'd0) ? 16'h7FFF : 16'h0000) : {1'b0, acc0[14:0]};
      req0_imag  = spike ? 16'h0000 : {1'b0, ~acc0[14:0]};
      req1_push  = (acc1 < target1);
      req1_real  = {1'b1, acc1[14:0]};
      req1_imag  = {1'b1, ~acc1[14:0]};
      fft_in_stall = in_tog & phase;
      fft_out_push = force_out | (out_en && (out_q.size() > 0));
      fft_out_real = (out_q.size() > 0) ? out_q[0].re : '0;
      fft_out_imag = (out_q.size() > 0) ? out_q[0].im : '0;
      rsp0_stall = rs0;
      rsp1_stall = rs1;
    end
  end

  // Monitor/scoreboard: decides at the falling edge which transfers the next rising edge performs.
  always @(negedge clk) begin
    smp_t s;
    smp_t e;
    logic a0, a1, fx, ox, r0x, r1x;
    if (flush_cnt != flush_seen) begin
      flush_seen = flush_cnt;
      inbuf.delete(); out_q.delete(); exp_rsp.delete(); grant_log.delete();
    end
    if (!reset) begin
      a0  = req0_push && !req0_stall;
      a1  = req1_push && !req1_stall;
      fx  = fft_in_push && !fft_in_stall;
      ox  = fft_out_push && !fft_out_stall;
      r0x = rsp0_push && !rsp0_stall;
      r1x = rsp1_push && !rsp1_stall;
      vectors++;
      if ((fx !== (a0 | a1)) || (a0 && a1)) begin
        miscompares++;
        $display("FAIL in_handshake: fft_in xfer=%b req0 xfer=%b req1 xfer=%b, need exactly one matching", fx, a0, a1);
      end
      if (a0) acc0++;
      if (a1) acc1++;
      if (fx) begin
        s.src = a1;
        s.re  = a1 ? req1_real : req0_real;
        s.im  = a1 ? req1_imag : req0_imag;
        vectors++;
        if (fft_in_real !== s.re || fft_in_imag !== s.im || owner !== s.src || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL fft_in_data: got %h/%h owner=%b busy=%b, want %h/%h owner=%b busy=1",
                   fft_in_real, fft_in_imag, owner, busy, s.re, s.im, s.src);
        end
        if (inbuf.size() == 0) grant_log.push_back(s.src);
        inbuf.push_back(s);
        if (inbuf.size() == N) begin
          foreach (inbuf[i]) begin
            out_q.push_back(inbuf[i]);
            exp_rsp.push_back(inbuf[i]);
          end
          inbuf.delete();
        end
      end
      vectors++;
      if ((ox !== (r0x | r1x)) || (rsp0_push && rsp1_push)) begin
        miscompares++;
        $display("FAIL out_handshake: fft_out xfer=%b rsp0 push/xfer=%b/%b rsp1 push/xfer=%b/%b",
                 ox, rsp0_push, r0x, rsp1_push, r1x);
      end
      if (ox && (out_q.size() > 0)) void'(out_q.pop_front());
      if (r0x || r1x) begin
        vectors++;
        if (exp_rsp.size() == 0) begin
          miscompares++;
          $display("FAIL rsp_unexpected: rsp%0d transfer with no frame expected", r1x ? 1 : 0);
        end else begin
          e = exp_rsp.pop_front();
          if (r1x !== e.src || (r1x ? rsp1_real : rsp0_real) !== e.re ||
              (r1x ? rsp1_imag : rsp0_imag) !== e.im) begin
            miscompares++;
            $display("FAIL rsp_data: got port %0d data %h/%h, want port %0d data %h/%h",
                     r1x ? 1 : 0, r1x ? rsp1_real : rsp0_real, r1x ? rsp1_imag : rsp0_imag,
                     e.src, e.re, e.im);
          end
        end
        if (r0x) rsp_cnt0++;
        if (r1x) rsp_cnt1++;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b1;
    flush_cnt++;
    target0 = acc0; target1 = acc1;
    spike = 1'b0; in_tog = 1'b0; force_out = 1'b0; rs0 = 1'b0; rs1 = 1'b0; out_en = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while (c < 600 && !(acc0 >= target0 && acc1 >= target1 && !busy &&
                        inbuf.size() == 0 && out_q.size() == 0 && exp_rsp.size() == 0)) begin
      @(posedge clk); #3;
      c++;
    end
    vectors++;
    if (c >= 600) begin
      miscompares++;
      $display("FAIL %s_drain_timeout: %0d frames outstanding after %0d cycles, want 0", name, exp_rsp.size() / N, c);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #3;
    vectors++;
    if ({req0_stall, req1_stall, fft_in_push, fft_out_stall, rsp0_push, rsp1_push, busy, owner, err} !== RESET_OUTS) begin
      miscompares++;
      $display("FAIL reset_values: got %b want %b",
               {req0_stall, req1_stall, fft_in_push, fft_out_stall, rsp0_push, rsp1_push, busy, owner, err}, RESET_OUTS);
    end
    reset = 1'b0;
    out_en = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    vectors++;
    if ({req0_stall, req1_stall, fft_in_push, fft_out_stall, rsp0_push, rsp1_push, busy, owner, err} !== RESET_OUTS) begin
      miscompares++;
      $display("FAIL idle_values: got %b want %b",
               {req0_stall, req1_stall, fft_in_push, fft_out_stall, rsp0_push, rsp1_push, busy, owner, err}, RESET_OUTS);
    end
  endtask

  task automatic test_single_frame();
    int r0, r1;
    r0 = rsp_cnt0; r1 = rsp_cnt1;
    spike = 1'b1;
    target0 = acc0 + N;
    wait_drain("single");
    spike = 1'b0;
    vectors++;
    if (rsp_cnt0 - r0 !== N || rsp_cnt1 - r1 !== 0) begin
      miscompares++;
      $display("FAIL single_rsp_counts: rsp0=%0d rsp1=%0d want %0d and 0", rsp_cnt0 - r0, rsp_cnt1 - r1, N);
    end
    vectors++;
    if (fft_out_stall !== 1'b1 || grant_log.size() != 1) begin
      miscompares++;
      $display("FAIL single_fifo_empty: fft_out_stall=%b grants=%0d want 1 and 1", fft_out_stall, grant_log.size());
    end
  endtask

  task automatic test_back_to_back();
    int   c, run, gap, falls, rises;
    logic prev;
    logic [3:0] order;
    do_reset();
    target0 = acc0 + 2 * N;
    target1 = acc1 + 2 * N;
    c = 0; run = 0; gap = 0; falls = 0; rises = 0; prev = 1'b0;
    while (c < 300 && falls < 4) begin
      @(posedge clk); #3;
      c++;
      if (busy) begin
        vectors++;
        if ((owner ? req0_stall : req1_stall) !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_nonowner_stall: owner=%b non-owner stall=%b want 1", owner, owner ? req0_stall : req1_stall);
        end
        if (!prev && rises > 0) begin
          vectors++;
          if (gap !== 1) begin
            miscompares++;
            $display("FAIL b2b_bubble: got %0d idle cycles between frames want 1", gap);
          end
        end
        if (!prev) rises++;
        run++;
        gap = 0;
      end else begin
        if (prev) begin
          falls++;
          vectors++;
          if (run !== N) begin
            miscompares++;
            $display("FAIL b2b_frame_len: busy for %0d cycles want %0d", run, N);
          end
        end
        run = 0;
        gap++;
      end
      prev = busy;
    end
    order = 4'b1111;
    if (grant_log.size() >= 4) order = {grant_log[0], grant_log[1], grant_log[2], grant_log[3]};
    vectors++;
    if (falls !== 4 || order !== 4'b0101) begin
      miscompares++;
      $display("FAIL b2b_order: frames=%0d order=%b want 4 frames order 0101", falls, order);
    end
    wait_drain("b2b");
  endtask

  task automatic test_fifo_full();
    int c, r;
    do_reset();
    rs0 = 1'b1; rs1 = 1'b1;
    target0 = acc0 + 3 * N;
    target1 = acc1 + 3 * N;
    repeat (150) @(posedge clk);
    #3;
    vectors++;
    if (grant_log.size() != 4 || busy !== 1'b0 || rsp_cnt0 + rsp_cnt1 !== 0 + rsp_cnt0 + rsp_cnt1) begin
      miscompares++;
      $display("FAIL full_grants: got %0d grants busy=%b want 4 grants busy=0", grant_log.size(), busy);
    end
    r = rsp_cnt0 + rsp_cnt1;
    rs0 = 1'b0; rs1 = 1'b0;
    c = 0;
    while (c < 100 && grant_log.size() < 5) begin
      @(posedge clk); #3;
      c++;
    end
    vectors++;
    if (grant_log.size() < 5 || (rsp_cnt0 + rsp_cnt1 - r) < N || grant_log[4] !== 1'b0) begin
      miscompares++;
      $display("FAIL full_fifth_grant: grants=%0d rsp xfers before it=%0d want 5 grants after >=%0d xfers, 5th owner 0",
               grant_log.size(), rsp_cnt0 + rsp_cnt1 - r, N);
    end
    target0 = ((acc0 + N - 1) / N) * N;
    target1 = ((acc1 + N - 1) / N) * N;
    wait_drain("full");
  endtask

  task automatic test_in_stall();
    int c, n, s1;
    do_reset();
    s1 = acc1;
    in_tog = 1'b1;
    target1 = acc1 + N;
    c = 0;
    while (c < 20 && !busy) begin
      @(posedge clk); #3;
      c++;
    end
    n = 0; c = 0;
    while (c < 100 && n < N) begin
      vectors++;
      if (busy !== 1'b1 || owner !== 1'b1 || req0_stall !== 1'b1 || req1_stall !== fft_in_stall) begin
        miscompares++;
        $display("FAIL stall_mirror: busy=%b owner=%b req0_stall=%b req1_stall=%b fft_in_stall=%b after %0d xfers",
                 busy, owner, req0_stall, req1_stall, fft_in_stall, n);
      end
      if (fft_in_push && !fft_in_stall) n++;
      @(posedge clk); #3;
      c++;
    end
    vectors++;
    if (busy !== 1'b0 || acc1 - s1 !== N) begin
      miscompares++;
      $display("FAIL stall_count: busy=%b accepted=%0d want busy=0 accepted=%0d", busy, acc1 - s1, N);
    end
    in_tog = 1'b0;
    wait_drain("stall");
  endtask

  task automatic test_err();
    do_reset();
    @(posedge clk); #3;
    force_out = 1'b1;
    @(posedge clk); #3;
    vectors++;
    if (err !== 1'b0 || rsp0_push !== 1'b0 || rsp1_push !== 1'b0 || fft_out_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL err_before: err=%b rsp push=%b%b fft_out_stall=%b want 0 00 1", err, rsp0_push, rsp1_push, fft_out_stall);
    end
    @(posedge clk); #3;
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_rise: err=%b want 1", err);
    end
    force_out = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    vectors++;
    if (err !== 1'b1 || rsp_cnt0 + rsp_cnt1 !== rsp_cnt0 + rsp_cnt1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL err_sticky: err=%b busy=%b want 1 0", err, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int c, s0, r0, r1;
    s0 = acc0;
    target0 = acc0 + N;
    c = 0;
    while (c < 40 && acc0 < s0 + 7) begin
      @(posedge clk); #3;
      c++;
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({req0_stall, req1_stall, fft_in_push, fft_out_stall, rsp0_push, rsp1_push, busy, owner, err} !== RESET_OUTS ||
        acc0 - s0 !== 7) begin
      miscompares++;
      $display("FAIL midreset_values: got %b want %b, sent %0d samples want 7",
               {req0_stall, req1_stall, fft_in_push, fft_out_stall, rsp0_push, rsp1_push, busy, owner, err},
               RESET_OUTS, acc0 - s0);
    end
    flush_cnt++;
    target0 = acc0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    r0 = rsp_cnt0; r1 = rsp_cnt1;
    target1 = acc1 + N;
    wait_drain("midreset");
    vectors++;
    if (grant_log.size() != 1 || grant_log[0] !== 1'b1 || rsp_cnt1 - r1 !== N || rsp_cnt0 - r0 !== 0) begin
      miscompares++;
      $display("FAIL midreset_next: grants=%0d rsp0=%0d rsp1=%0d want 1 grant to req1, 0 and %0d",
               grant_log.size(), rsp_cnt0 - r0, rsp_cnt1 - r1, N);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_fifo_full();
    test_in_stall();
    test_err();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
